// File: rtl/video_timing_pkg.sv
// video_timing_pkg: 640x480@60 raster constants and raster sequencing states.
package video_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/video_timing_controller_if.sv
// video_timing_controller_if: run request in, registered raster timing out.
interface video_timing_controller_if
  import video_timing_pkg::*;
#(
  parameter int w_x = $clog2(H_ACTIVE),
  parameter int w_y = $clog2(V_ACTIVE)
);
  logic en;
  logic pixel_en;
  logic hsync;
  logic vsync;
  logic display_on;
  logic [w_x-1:0] x;
  logic [w_y-1:0] y;
  logic line_start;
  logic frame_start;
  logic running;
  modport master(
    input en,
    output pixel_en, hsync, vsync, display_on, x, y, line_start, frame_start, running
  );
  modport slave(
    output en,
    input pixel_en, hsync, vsync, display_on, x, y, line_start, frame_start, running
  );
endinterface

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: phase accumulator giving pixel_mhz ticks per clk_mhz clocks.
module pixel_tick_gen #(
  parameter int clk_mhz = 125,
  parameter int pixel_mhz = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(clk_mhz + pixel_mhz + 1);
  localparam logic [W-1:0] C = W'(clk_mhz);
  localparam logic [W-1:0] P = W'(pixel_mhz);
  logic [W-1:0] acc, sum;
  always_comb begin
    sum = acc + P;
    tick = !clear && sum >= C;
  end
  always_ff @(posedge clk)
    acc <= (rst || clear) ? '0 : tick ? sum - C : sum;
endmodule

// File: rtl/video_timing_controller.sv
// video_timing_controller: fractional pixel enable, raster counters and run/drain sequencing.
module video_timing_controller
  import video_timing_pkg::*;
#(
  parameter int clk_mhz = 125,
  parameter int pixel_mhz = 25,
  parameter int h_active = H_ACTIVE,
  parameter int h_front = H_FRONT,
  parameter int h_sync = H_SYNC,
  parameter int h_back = H_BACK,
  parameter int v_active = V_ACTIVE,
  parameter int v_front = V_FRONT,
  parameter int v_sync = V_SYNC,
  parameter int v_back = V_BACK,
  parameter int hsync_low = 1,
  parameter int vsync_low = 1,
  parameter int w_x = $clog2(h_active),
  parameter int w_y = $clog2(v_active)
) (
  input logic clk,
  input logic rst,
  video_timing_controller_if.master vif
);
  localparam int h_tot = h_active + h_front + h_sync + h_back;
  localparam int v_tot = v_active + v_front + v_sync + v_back;
  localparam int HW = $clog2(h_tot);
  localparam int VW = $clog2(v_tot);
  localparam logic [HW-1:0] H_LAST = HW'(h_tot - 1);
  localparam logic [VW-1:0] V_LAST = VW'(v_tot - 1);
  localparam logic [HW-1:0] HA = HW'(h_active);
  localparam logic [HW-1:0] HS0 = HW'(h_active + h_front);
  localparam logic [HW-1:0] HS1 = HW'(h_active + h_front + h_sync);
  localparam logic [VW-1:0] VA = VW'(v_active);
  localparam logic [VW-1:0] VS0 = VW'(v_active + v_front);
  localparam logic [VW-1:0] VS1 = VW'(v_active + v_front + v_sync);
  localparam logic HL = hsync_low != 0;
  localparam logic VL = vsync_low != 0;
  if (pixel_mhz <= 0 || pixel_mhz > clk_mhz || h_active <= 0 || h_front <= 0 || h_sync <= 0 ||
      h_back <= 0 || v_active <= 0 || v_front <= 0 || v_sync <= 0 || v_back <= 0) begin : g_bad
    $fatal(1, "video_timing_controller: invalid timing parameters");
  end
  state_t state, state_nx;
  logic tick, last_h, last, act, hs_on, vs_on;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  pixel_tick_gen #(.clk_mhz(clk_mhz), .pixel_mhz(pixel_mhz)) u_tick (
    .clk(clk), .rst(rst), .clear(state == IDLE), .tick(tick)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // en always wins, so a re-raise during DRAIN leaves the raster untouched
  always_comb begin
    state_nx = vif.en ? RUN : state == IDLE ? IDLE : state == RUN ? DRAIN : (tick && last) ? IDLE : DRAIN;
    last_h = h == H_LAST;
    last = last_h && v == V_LAST;
    act = h < HA && v < VA;
    hs_on = h >= HS0 && h < HS1;
    vs_on = v >= VS0 && v < VS1;
  end
  always_ff @(posedge clk)
    if (rst || state == IDLE) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      h <= last_h ? '0 : h + 1'b1;
      if (last_h) v <= v == V_LAST ? '0 : v + 1'b1;
    end
  // outputs decode the pre-increment counters, so the first tick shows (0,0)
  always_ff @(posedge clk)
    if (rst || state == IDLE) begin
      vif.pixel_en <= 1'b0;
      vif.line_start <= 1'b0;
      vif.frame_start <= 1'b0;
      vif.display_on <= 1'b0;
      vif.hsync <= HL;
      vif.vsync <= VL;
      vif.x <= '0;
      vif.y <= '0;
    end else begin
      vif.pixel_en <= tick;
      vif.line_start <= tick && h == '0;
      vif.frame_start <= tick && h == '0 && v == '0;
      if (tick) begin
        vif.display_on <= act;
        vif.hsync <= hs_on ^ HL;
        vif.vsync <= vs_on ^ VL;
        vif.x <= act ? w_x'(h) : '0;
        vif.y <= act ? w_y'(v) : '0;
      end
    end
  assign vif.running = state != IDLE;
endmodule

// File: tb/tb_video_timing_controller.sv
// tb_video_timing_controller: directed checks on a 15x8 raster plus a 27/25 tick-rate run.
module tb_video_timing_controller;
  typedef struct {
    int h;
    int v;
    logic [9:0] e;
  } vec_t;
  localparam logic [9:0] RST = 10'b0110000000;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  video_timing_controller_if #(.w_x(3), .w_y(2)) vif ();
  video_timing_controller_if #(.w_x(10), .w_y(9)) vif2 ();
  video_timing_controller #(
    .clk_mhz(125), .pixel_mhz(25),
    .h_active(8), .h_front(2), .h_sync(3), .h_back(2),
    .v_active(4), .v_front(1), .v_sync(2), .v_back(1),
    .hsync_low(1), .vsync_low(1), .w_x(3), .w_y(2)
  ) dut (.clk(clk), .rst(rst), .vif(vif));
  video_timing_controller #(.clk_mhz(27), .pixel_mhz(25), .w_x(10), .w_y(9)) dut2 (
    .clk(clk), .rst(rst), .vif(vif2)
  );
  int checks = 0;
  int errors = 0;
  int gap;
  vec_t tbl[15];
  task automatic check(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  function automatic logic [9:0] ex(logic d, logic hs, logic vs, logic ls, logic fs, logic [2:0] x, logic [1:0] y);
    return {d, hs, vs, ls, fs, x, y};
  endfunction
  function automatic logic [9:0] pk();
    return {vif.display_on, vif.hsync, vif.vsync, vif.line_start, vif.frame_start, vif.x, vif.y};
  endfunction
  task automatic step();
    logic ok;
    ok = 1'b0;
    gap = 0;
    while (!ok && gap < 30) begin
      @(negedge clk);
      gap++;
      ok = vif.pixel_en;
    end
    check("pixel_en within 30 clk", 32'(ok), 1);
  endtask
  initial begin
    int cnt, nd, nhs, nvs, nls, nfs, ngap, last, maxgap;
    tbl[0] = '{0, 0, ex(1, 1, 1, 1, 1, 0, 0)};
    tbl[1] = '{7, 0, ex(1, 1, 1, 0, 0, 7, 0)};
    tbl[2] = '{8, 0, ex(0, 1, 1, 0, 0, 0, 0)};
    tbl[3] = '{9, 1, ex(0, 1, 1, 0, 0, 0, 0)};
    tbl[4] = '{10, 1, ex(0, 0, 1, 0, 0, 0, 0)};
    tbl[5] = '{12, 2, ex(0, 0, 1, 0, 0, 0, 0)};
    tbl[6] = '{13, 2, ex(0, 1, 1, 0, 0, 0, 0)};
    tbl[7] = '{0, 1, ex(1, 1, 1, 1, 0, 0, 1)};
    tbl[8] = '{3, 2, ex(1, 1, 1, 0, 0, 3, 2)};
    tbl[9] = '{7, 3, ex(1, 1, 1, 0, 0, 7, 3)};
    tbl[10] = '{0, 4, ex(0, 1, 1, 1, 0, 0, 0)};
    tbl[11] = '{4, 5, ex(0, 1, 0, 0, 0, 0, 0)};
    tbl[12] = '{11, 6, ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[13] = '{0, 7, ex(0, 1, 1, 1, 0, 0, 0)};
    tbl[14] = '{14, 7, ex(0, 1, 1, 0, 0, 0, 0)};
    rst = 1'b1;
    vif.en = 1'b0;
    vif2.en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'(pk()), 32'(RST));
    check("reset pixel_en", 32'(vif.pixel_en), 0);
    check("reset running", 32'(vif.running), 0);
    rst = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      cnt += 32'(vif.pixel_en);
    end
    check("idle pixel_en count", cnt, 0);
    vif.en = 1'b1;
    {nd, nhs, nvs, nls, nfs, ngap} = '0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (i > 0 && gap != 5) ngap++;
      nd += 32'(vif.display_on);
      nhs += 32'(!vif.hsync);
      nvs += 32'(!vif.vsync);
      nls += 32'(vif.line_start);
      nfs += 32'(vif.frame_start);
      foreach (tbl[k])
        if (tbl[k].h == i % 15 && tbl[k].v == i / 15)
          check($sformatf("pixel(%0d,%0d)", tbl[k].h, tbl[k].v), 32'(pk()), 32'(tbl[k].e));
    end
    check("pixel spacing errors", ngap, 0);
    check("display_on per frame", nd, 32);
    check("hsync low per frame", nhs, 24);
    check("vsync low per frame", nvs, 30);
    check("line_start per frame", nls, 8);
    check("frame_start per frame", nfs, 1);
    step();
    check("frame2 frame_start", 32'(vif.frame_start), 1);
    check("frame2 seamless gap", gap, 5);
    for (int i = 1; i <= 33; i++) step();
    check("pixel(3,2) frame2", 32'(pk()), 32'(ex(1, 1, 1, 0, 0, 3, 2)));
    vif.en = 1'b0;
    for (int i = 34; i < 120; i++) begin
      step();
      if (i == 60) check("running in drain", 32'(vif.running), 1);
    end
    check("drain last pixel", 32'(pk()), 32'(ex(0, 1, 1, 0, 0, 0, 0)));
    @(negedge clk);
    check("after drain outputs", 32'(pk()), 32'(RST));
    check("after drain running", 32'(vif.running), 0);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      cnt += 32'(vif.pixel_en);
    end
    check("halted pixel_en count", cnt, 0);
    vif.en = 1'b1;
    step();
    check("restart frame_start", 32'(vif.frame_start), 1);
    for (int i = 1; i <= 33; i++) step();
    vif.en = 1'b0;
    for (int i = 34; i <= 80; i++) step();
    vif.en = 1'b1;
    for (int i = 81; i < 120; i++) step();
    step();
    check("re-raise frame_start", 32'(vif.frame_start), 1);
    check("re-raise seamless gap", gap, 5);
    check("re-raise running", 32'(vif.running), 1);
    for (int i = 1; i <= 95; i++) step();
    check("pixel(5,6)", 32'(pk()), 32'(ex(0, 1, 0, 0, 0, 0, 0)));
    rst = 1'b1;
    @(negedge clk);
    check("mid-frame rst outputs", 32'(pk()), 32'(RST));
    check("mid-frame rst pixel_en", 32'(vif.pixel_en), 0);
    check("mid-frame rst running", 32'(vif.running), 0);
    rst = 1'b0;
    step();
    check("post-rst first pixel", 32'(pk()), 32'(ex(1, 1, 1, 1, 1, 0, 0)));
    vif2.en = 1'b1;
    cnt = 0;
    while (!vif2.running && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("27/25 running", 32'(vif2.running), 1);
    repeat (2) @(negedge clk);
    cnt = 0;
    last = -1;
    maxgap = 0;
    for (int c = 0; c < 27000; c++) begin
      @(negedge clk);
      if (vif2.pixel_en) begin
        cnt++;
        if (last >= 0 && c - last > maxgap) maxgap = c - last;
        last = c;
      end
    end
    check("27/25 pixel_en count", cnt, 25000);
    check("27/25 max gap", maxgap, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
